// File: rtl/softmax_exp_sched_pkg.sv
// Shared types and constants for the softmax exp-stage scheduler.
// Lane count, skid FIFO depth, FSM states and tail-mask helper.
package softmax_exp_sched_pkg;

  localparam int LANES      = 4;
  localparam int FIFO_DEPTH = 2;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_ADDRW     = 8;
  localparam int DEF_LENW      = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Lane mask of the final beat from num_elems % 4.
  function automatic logic [LANES-1:0] tail_mask(
    input logic [1:0] rem
  );
    logic [LANES-1:0] m;
    case (rem)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/softmax_exp_sched_fifo.sv
// Two-entry skid FIFO holding exp results and lane masks.
// The head entry is a register and drives the output directly.
module softmax_exp_sched_fifo #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  logic [W-1:0] ent1;

  // Head/tail storage and occupancy; the scheduler's credit
  // check keeps push away from a full FIFO unless a pop frees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) dout <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          dout <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            dout <= din;
          end else begin
            dout <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/softmax_exp_sched.sv
// Streams one softmax vector through the 4-lane exp stage and
// forwards results to the exp-result buffer via valid/ready.
module softmax_exp_sched
  import softmax_exp_sched_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRW     = DEF_ADDRW,
  parameter int LENW      = DEF_LENW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDRW-1:0]           rd_base,
  input  logic [ADDRW-1:0]           wr_base,
  input  logic [LENW-1:0]            num_elems,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [ADDRW-1:0]           rd_addr,
  input  logic [LANES*DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0]       exp_inp0,
  output logic [DATAWIDTH-1:0]       exp_inp1,
  output logic [DATAWIDTH-1:0]       exp_inp2,
  output logic [DATAWIDTH-1:0]       exp_inp3,
  input  logic [DATAWIDTH-1:0]       exp_outp0,
  input  logic [DATAWIDTH-1:0]       exp_outp1,
  input  logic [DATAWIDTH-1:0]       exp_outp2,
  input  logic [DATAWIDTH-1:0]       exp_outp3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDRW-1:0]           out_addr,
  output logic [LANES*DATAWIDTH-1:0] out_data,
  output logic [LANES-1:0]           out_mask
);

  localparam int DW = LANES * DATAWIDTH;
  localparam int BW = DW + LANES;

  state_e           state_q;
  state_e           state_d;
  logic             take_start;

  logic [ADDRW-1:0] rd_base_q;
  logic [ADDRW-1:0] wr_base_q;
  logic [1:0]       tail_q;
  logic [LENW-1:0]  beats_q;
  logic [LENW-1:0]  issued_q;
  logic [LENW-1:0]  accepted_q;
  logic [LENW-1:0]  beats_in;

  logic             inflight_q;
  logic             last_q;

  logic             pop;
  logic [1:0]       fifo_cnt;
  logic [2:0]       occ;
  logic [BW-1:0]    fifo_din;
  logic [BW-1:0]    fifo_dout;
  logic [LANES-1:0] beat_mask;

  assign beats_in = {2'b00, num_elems[LENW-1:2]}
                  + {{(LENW-1){1'b0}}, |num_elems[1:0]};

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;

  // Outstanding beats (FIFO + read in flight) net of this cycle's pop.
  assign occ = {1'b0, fifo_cnt}
             + {2'b00, inflight_q}
             - {2'b00, pop};

  assign rd_en = (state_q == S_RUN)
               && (issued_q != beats_q)
               && (occ < 3'(FIFO_DEPTH));

  assign rd_addr  = rd_base_q + ADDRW'(issued_q);
  assign out_addr = wr_base_q + ADDRW'(accepted_q);

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // Lanes only see read data in the cycle it is valid.
  assign exp_inp0 = inflight_q ? rd_data[0*DATAWIDTH +: DATAWIDTH] : '0;
  assign exp_inp1 = inflight_q ? rd_data[1*DATAWIDTH +: DATAWIDTH] : '0;
  assign exp_inp2 = inflight_q ? rd_data[2*DATAWIDTH +: DATAWIDTH] : '0;
  assign exp_inp3 = inflight_q ? rd_data[3*DATAWIDTH +: DATAWIDTH] : '0;

  assign beat_mask = last_q ? tail_mask(tail_q) : {LANES{1'b1}};
  assign fifo_din  = {beat_mask, exp_outp3, exp_outp2,
                      exp_outp1, exp_outp0};

  assign out_data = fifo_dout[DW-1:0];
  assign out_mask = fifo_dout[DW +: LANES];

  // Next-state: zero-length vectors skip straight to DONE.
  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          if (num_elems == '0) state_d = S_DONE;
          else                 state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issued_q == beats_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (accepted_q + LENW'(pop) == beats_q)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Vector parameters captured on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_base_q <= '0;
      wr_base_q <= '0;
      tail_q    <= 2'd0;
      beats_q   <= '0;
    end else if (take_start) begin
      rd_base_q <= rd_base;
      wr_base_q <= wr_base;
      tail_q    <= num_elems[1:0];
      beats_q   <= beats_in;
    end
  end

  // Beat counters for issued reads and accepted writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q   <= '0;
      accepted_q <= '0;
    end else if (take_start) begin
      issued_q   <= '0;
      accepted_q <= '0;
    end else begin
      if (rd_en) issued_q   <= issued_q + LENW'(1);
      if (pop)   accepted_q <= accepted_q + LENW'(1);
    end
  end

  // Track the read in flight and whether it is the final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      last_q     <= rd_en && (issued_q == beats_q - LENW'(1));
    end
  end

  softmax_exp_sched_fifo #(
    .W (BW)
  ) u_exp_skid_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_softmax_exp_sched.sv
// Self-checking bench for softmax_exp_sched with a scratch-buffer
// responder, an exp-lane stand-in and an in-order beat scoreboard.
module tb_softmax_exp_sched;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [3:0]  mask;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rd_base = '0;
  logic [7:0]  wr_base = '0;
  logic [9:0]  num_elems = '0;
  logic        busy, done, rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic [15:0] exp_inp0, exp_inp1, exp_inp2, exp_inp3;
  logic [15:0] exp_outp0, exp_outp1, exp_outp2, exp_outp3;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_addr;
  logic [63:0] out_data;
  logic [3:0]  out_mask;

  logic [63:0] mem [256];

  int total = 0;
  int bad = 0;

  beat_t sb[$];
  logic [7:0] m_rb, m_wb;
  int m_n, m_beats, m_iss, m_acc;
  int rd_seen = 0;
  int val_seen = 0;
  bit prev_stall = 0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_f(input logic [15:0] x);
    if (x == 16'h0000) return 16'h3C00;
    if (x == 16'h3C00) return 16'h4170;
    return {x[7:0], x[15:8]} ^ 16'h0F0F;
  endfunction

  function automatic logic [63:0] exp4(input logic [63:0] d);
    return {exp_f(d[63:48]), exp_f(d[47:32]),
            exp_f(d[31:16]), exp_f(d[15:0])};
  endfunction

  assign exp_outp0 = exp_f(exp_inp0);
  assign exp_outp1 = exp_f(exp_inp1);
  assign exp_outp2 = exp_f(exp_inp2);
  assign exp_outp3 = exp_f(exp_inp3);

  softmax_exp_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_base   (rd_base),
    .wr_base   (wr_base),
    .num_elems (num_elems),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .exp_inp0  (exp_inp0),
    .exp_inp1  (exp_inp1),
    .exp_inp2  (exp_inp2),
    .exp_inp3  (exp_inp3),
    .exp_outp0 (exp_outp0),
    .exp_outp1 (exp_outp1),
    .exp_outp2 (exp_outp2),
    .exp_outp3 (exp_outp3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  // Scratch buffer: data valid one cycle after rd_en, noise otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= {$urandom, $urandom};
  end

  // Scoreboard: push expectation on each read, pop on each accept.
  always @(negedge clk) begin
    beat_t e;
    logic [7:0] a;
    logic [63:0] dm;
    if (reset) begin
      sb.delete();
      m_iss = 0;
      m_acc = 0;
      prev_stall = 0;
    end else begin
      if (start && !busy) begin
        m_rb = rd_base;
        m_wb = wr_base;
        m_n = int'(num_elems);
        m_beats = (m_n + 3) / 4;
        m_iss = 0;
        m_acc = 0;
      end
      if (prev_stall) begin
        total++;
        if (!out_valid || out_addr !== prev_beat.addr ||
            out_data !== prev_beat.data ||
            out_mask !== prev_beat.mask) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b a=%h d=%h m=%h want a=%h d=%h m=%h",
                   out_valid, out_addr, out_data, out_mask,
                   prev_beat.addr, prev_beat.data, prev_beat.mask);
        end
      end
      if (rd_en) begin
        a = m_rb + 8'(m_iss);
        total++;
        if (rd_addr !== a) begin
          bad++;
          $display("FAIL rd_addr: got %h want %h", rd_addr, a);
        end
        e.addr = m_wb + 8'(m_iss);
        e.data = exp4(mem[a]);
        if (m_iss == m_beats - 1 && (m_n % 4) != 0)
          e.mask = 4'((1 << (m_n % 4)) - 1);
        else
          e.mask = 4'hF;
        sb.push_back(e);
        m_iss++;
        rd_seen++;
      end
      if (out_valid) val_seen++;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat_extra: got a=%h d=%h want none",
                   out_addr, out_data);
        end else begin
          e = sb.pop_front();
          dm = {{16{e.mask[3]}}, {16{e.mask[2]}},
                {16{e.mask[1]}}, {16{e.mask[0]}}};
          if (out_addr !== e.addr || out_mask !== e.mask ||
              (out_data & dm) !== (e.data & dm)) begin
            bad++;
            $display("FAIL beat: got a=%h d=%h m=%h want a=%h d=%h m=%h",
                     out_addr, out_data, out_mask,
                     e.addr, e.data, e.mask);
          end
        end
        m_acc++;
      end
      if (rd_en) begin
        total++;
        if (m_iss - m_acc > 2) begin
          bad++;
          $display("FAIL pending: got %0d want <=2", m_iss - m_acc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat.addr = out_addr;
      prev_beat.data = out_data;
      prev_beat.mask = out_mask;
    end
  end

  task automatic start_vec(input logic [7:0] rb, input logic [7:0] wb,
                           input logic [9:0] n);
    @(posedge clk); #1;
    rd_base = rb;
    wr_base = wb;
    num_elems = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, rd_en, out_valid} !== 4'b0 ||
        rd_addr !== 8'h0 || out_addr !== 8'h0 ||
        out_data !== 64'h0 || out_mask !== 4'h0 ||
        exp_inp0 !== 16'h0) begin
      bad++;
      $display("FAIL reset_outs: got b=%b d=%b r=%b v=%b a=%h want all 0",
               busy, done, rd_en, out_valid, out_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_zero_input();
    logic [2:0] tbl [6];
    logic [7:0] atbl [6];
    tbl[0] = 3'b100; tbl[1] = 3'b100; tbl[2] = 3'b010;
    tbl[3] = 3'b010; tbl[4] = 3'b001; tbl[5] = 3'b000;
    atbl[2] = 8'd40; atbl[3] = 8'd41;
    mem[10] = 64'h0;
    mem[11] = 64'h0;
    out_ready = 1'b1;
    start_vec(8'd10, 8'd40, 10'd8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({rd_en, out_valid, done} !== tbl[i] ||
          busy !== (i < 5)) begin
        bad++;
        $display("FAIL lat_c%0d: got rd=%b v=%b d=%b busy=%b want %b busy=%b",
                 i + 1, rd_en, out_valid, done, busy, tbl[i], (i < 5));
      end
      if (i == 2 || i == 3) begin
        total++;
        if (out_data !== {4{16'h3C00}} || out_mask !== 4'hF ||
            out_addr !== atbl[i]) begin
          bad++;
          $display("FAIL zero_beat%0d: got a=%h d=%h m=%h want a=%h d=%h m=f",
                   i - 2, out_addr, out_data, out_mask, atbl[i],
                   {4{16'h3C00}});
        end
      end
    end
  endtask

  task automatic test_partial();
    bit ok;
    mem[20] = {4{16'h3C00}};
    mem[21] = {4{16'h3C00}};
    out_ready = 1'b1;
    start_vec(8'd20, 8'd60, 10'd6);
    wait_done(40, ok);
    total++;
    if (!ok || m_acc != 2 || sb.size() != 0) begin
      bad++;
      $display("FAIL partial: got done=%0b acc=%0d left=%0d want 1 2 0",
               ok, m_acc, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok = 0;
    for (int i = 0; i < 4; i++) mem[100 + i] = {$urandom, $urandom};
    start_vec(8'd100, 8'd200, 10'd16);
    for (int i = 0; i < 80; i++) begin
      out_ready = (i >= 6 && i < 14) ? 1'b0 : ~i[0];
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++;
    if (!ok || m_acc != 4 || m_iss != 4 || sb.size() != 0) begin
      bad++;
      $display("FAIL backpressure: got done=%0b acc=%0d iss=%0d left=%0d want 1 4 4 0",
               ok, m_acc, m_iss, sb.size());
    end
  endtask

  task automatic test_empty();
    int r0, v0;
    r0 = rd_seen;
    v0 = val_seen;
    out_ready = 1'b1;
    start_vec(8'd5, 8'd6, 10'd0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL empty_c1: got busy=%b done=%b want 1 1", busy, done);
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        rd_seen != r0 || val_seen != v0) begin
      bad++;
      $display("FAIL empty_after: got busy=%b done=%b rd=%0d v=%0d want 0 0 0 0",
               busy, done, rd_seen - r0, val_seen - v0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[8'hFE] = {$urandom, $urandom};
    mem[8'hFF] = {$urandom, $urandom};
    mem[8'h00] = {$urandom, $urandom};
    out_ready = 1'b1;
    start_vec(8'hFE, 8'hFF, 10'd12);
    wait_done(40, ok);
    total++;
    if (!ok || m_acc != 3 || sb.size() != 0) begin
      bad++;
      $display("FAIL wrap: got done=%0b acc=%0d left=%0d want 1 3 0",
               ok, m_acc, sb.size());
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit saw_done = 0;
    for (int i = 0; i < 4; i++) mem[30 + i] = {$urandom, $urandom};
    mem[50] = {$urandom, $urandom};
    mem[51] = {$urandom, $urandom};
    out_ready = 1'b0;
    start_vec(8'd30, 8'd80, 10'd16);
    @(posedge clk);
    @(posedge clk); #2;
    total++;
    if (out_valid !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: got v=%b rd=%b busy=%b want 1 0 1",
               out_valid, rd_en, busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, rd_en, out_valid} !== 4'b0 ||
        out_addr !== 8'h0 || out_data !== 64'h0 ||
        out_mask !== 4'h0 || rd_addr !== 8'h0 ||
        exp_inp0 !== 16'h0) begin
      bad++;
      $display("FAIL abort_async: got b=%b d=%b r=%b v=%b a=%h m=%h want 0",
               busy, done, rd_en, out_valid, out_addr, out_mask);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy || out_valid) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL abort_quiet: got activity=1 want 0");
    end
    start_vec(8'd50, 8'd90, 10'd5);
    wait_done(40, ok);
    total++;
    if (!ok || m_acc != 2 || m_iss != 2 || sb.size() != 0) begin
      bad++;
      $display("FAIL abort_restart: got done=%0b acc=%0d iss=%0d left=%0d want 1 2 2 0",
               ok, m_acc, m_iss, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_zero_input();
    test_partial();
    test_backpressure();
    test_empty();
    test_wrap();
    test_abort();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
